if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a one-entry skid buffer and IF/ID register.
// The instruction memory answers one cycle after imem_en. A stall freezes the
// PC and IF/ID, and the single in-flight response is caught in the skid
// register. A redirect overrides a stall and flushes IF/ID to a NOP bubble.
// Optional build macro: IF_STAGE_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module if_stage #(
   parameter logic [8:0] RESET_PC = 9'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [8:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [49:0] if_id_q,
   output logic        if_id_valid
`ifdef IF_STAGE_BUBBLE_CNT_EN
   ,
   output logic [15:0] bubble_cnt
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [8:0]  fetch_pc;
   logic [8:0]  req_pc;
   logic        req_valid;
   logic [31:0] skid_inst;
   logic [8:0]  skid_pc;
   logic        skid_valid;
   logic [31:0] ifid_inst;
   logic [8:0]  ifid_pc;
   logic [8:0]  ifid_pc4;
   logic        ifid_valid;
   logic [8:0]  redir_addr;

   // Only the word-aligned low byte-address bits of the jump target matter.
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^{redirect_pc[31:9], redirect_pc[1:0]};

   // Fetch request: a redirect always issues, otherwise issue unless stalled.
   always_comb begin
      redir_addr = {redirect_pc[8:2], 2'b00};
      imem_en    = rst_n & (redirect | ~stall);
      imem_addr  = redirect ? redir_addr : fetch_pc;
   end

   // Fetch PC, in-flight tag and skid buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         req_pc     <= 9'h000;
         req_valid  <= 1'b0;
         skid_inst  <= NOP;
         skid_pc    <= 9'h000;
         skid_valid <= 1'b0;
      end else if (redirect) begin
         fetch_pc   <= redir_addr + 9'd4;
         req_pc     <= redir_addr;
         req_valid  <= 1'b1;
         skid_valid <= 1'b0;
      end else if (stall) begin
         // Catch the one response still coming back; nothing new is issued.
         if (req_valid && !skid_valid) begin
            skid_inst  <= imem_rdata;
            skid_pc    <= req_pc;
            skid_valid <= 1'b1;
            req_valid  <= 1'b0;
         end
      end else begin
         fetch_pc   <= fetch_pc + 9'd4;
         req_pc     <= fetch_pc;
         req_valid  <= 1'b1;
         skid_valid <= 1'b0;
      end
   end

   // IF/ID register: flush on redirect, hold on stall, skid drains first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_inst  <= NOP;
         ifid_pc    <= 9'h000;
         ifid_pc4   <= 9'h000;
         ifid_valid <= 1'b0;
      end else if (redirect) begin
         ifid_inst  <= NOP;
         ifid_pc    <= 9'h000;
         ifid_pc4   <= 9'h000;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         if (skid_valid) begin
            ifid_inst  <= skid_inst;
            ifid_pc    <= skid_pc;
            ifid_pc4   <= skid_pc + 9'd4;
            ifid_valid <= 1'b1;
         end else begin
            ifid_inst  <= imem_rdata;
            ifid_pc    <= req_pc;
            ifid_pc4   <= req_pc + 9'd4;
            ifid_valid <= req_valid;
         end
      end
   end

   assign if_id_q     = {ifid_inst, ifid_pc, ifid_pc4};
   assign if_id_valid = ifid_valid;

`ifdef IF_STAGE_BUBBLE_CNT_EN
   logic new_bubble;
   assign new_bubble = redirect | (~stall & ~skid_valid & ~req_valid);

   // Count edges that load an invalid packet into IF/ID; stall holds are not bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= 16'h0000;
      end else if (new_bubble && (bubble_cnt != 16'hFFFF)) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a registered instruction memory model.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [8:0]  imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic [49:0] if_id_q;
   logic        if_id_valid;
`ifdef IF_STAGE_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt;
`endif

   int nchk = 0;
   int nerr = 0;

   if_stage #(.RESET_PC(9'h000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .if_id_q     (if_id_q),
      .if_id_valid (if_id_valid)
`ifdef IF_STAGE_BUBBLE_CNT_EN
      ,
      .bubble_cnt  (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [8:0] a);
      mem = (a == 9'h000) ? 32'h0010_0093 : {16'hCAFE, 7'h00, a};
   endfunction

   // Memory answers one cycle after a strobe; garbage otherwise.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem(imem_addr);
      else         imem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      chk("rst_valid", 64'(if_id_valid), 64'd0);
      chk("rst_q", 64'(if_id_q), 64'({NOP, 18'h0}));
      chk("rst_en", 64'(imem_en), 64'd0);

      rst_n = 1'b1; #1;
      chk("c0_en", 64'(imem_en), 64'd1);
      chk("c0_addr", 64'(imem_addr), 64'h000);
      tick(); // E1
      chk("e1_bubble", 64'(if_id_valid), 64'd0);
      chk("e1_addr", 64'(imem_addr), 64'h004);
`ifdef IF_STAGE_BUBBLE_CNT_EN
      chk("e1_bcnt", 64'(bubble_cnt), 64'd1);
`endif
      tick(); // E2
      chk("e2_q", 64'(if_id_q), 64'({32'h0010_0093, 9'h000, 9'h004}));
      chk("e2_valid", 64'(if_id_valid), 64'd1);
      chk("e2_addr", 64'(imem_addr), 64'h008);
      tick(); // E3: 0x008 in flight
      chk("e3_pc", 64'(if_id_q[17:9]), 64'h004);

      stall = 1'b1; #1;
      chk("stall_en", 64'(imem_en), 64'd0);
      tick(); // E4
      chk("stall_hold1", 64'(if_id_q[17:9]), 64'h004);
      chk("stall_en2", 64'(imem_en), 64'd0);
      tick(); tick(); // E5, E6
      chk("stall_hold3", 64'(if_id_q), 64'({mem(9'h004), 9'h004, 9'h008}));
      chk("stall_hold_v", 64'(if_id_valid), 64'd1);
      stall = 1'b0; #1;
      chk("rel_addr", 64'(imem_addr), 64'h00C);
      tick(); // E7
      chk("skid_q", 64'(if_id_q), 64'({mem(9'h008), 9'h008, 9'h00C}));
      chk("skid_v", 64'(if_id_valid), 64'd1);
      tick(); // E8
      chk("after_skid_q", 64'(if_id_q), 64'({mem(9'h00C), 9'h00C, 9'h010}));

      redirect = 1'b1; redirect_pc = 32'h0000_0043; #1;
      chk("redir_addr", 64'(imem_addr), 64'h040);
      chk("redir_en", 64'(imem_en), 64'd1);
      tick(); // E9
      redirect = 1'b0;
      chk("flush_q", 64'(if_id_q), 64'({NOP, 18'h0}));
      chk("flush_v", 64'(if_id_valid), 64'd0);
`ifdef IF_STAGE_BUBBLE_CNT_EN
      chk("e9_bcnt", 64'(bubble_cnt), 64'd2);
`endif
      #1;
      chk("redir_next_addr", 64'(imem_addr), 64'h044);
      tick(); // E10
      chk("redir_tgt_q", 64'(if_id_q), 64'({mem(9'h040), 9'h040, 9'h044}));
      chk("redir_tgt_v", 64'(if_id_valid), 64'd1);

      stall = 1'b1;
      tick(); // E11: 0x044 goes to skid
      chk("st2_hold", 64'(if_id_q[17:9]), 64'h040);
      redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;
      chk("rs_en", 64'(imem_en), 64'd1);
      chk("rs_addr", 64'(imem_addr), 64'h100);
      tick(); // E12
      redirect = 1'b0; stall = 1'b0; #1;
      chk("rs_fetch", 64'(imem_addr), 64'h104);
      chk("rs_flush_v", 64'(if_id_valid), 64'd0);
`ifdef IF_STAGE_BUBBLE_CNT_EN
      chk("e12_bcnt", 64'(bubble_cnt), 64'd3);
`endif
      tick(); // E13: skid must have been dropped
      chk("rs_q", 64'(if_id_q), 64'({mem(9'h100), 9'h100, 9'h104}));

      redirect = 1'b1; redirect_pc = 32'h0000_01F8;
      tick(); // E14
      redirect = 1'b0;
      tick(); // E15
      chk("wrap_pc_prev", 64'(if_id_q[17:9]), 64'h1F8);
      chk("wrap_fetch", 64'(imem_addr), 64'h000);
      tick(); // E16
      chk("wrap_q", 64'(if_id_q), 64'({mem(9'h1FC), 9'h1FC, 9'h000}));
      chk("wrap_v", 64'(if_id_valid), 64'd1);

      stall = 1'b1;
      tick(); // E17: 0x000 in skid
      #2; rst_n = 1'b0; #1;
      chk("mid_rst_en", 64'(imem_en), 64'd0);
      chk("mid_rst_v", 64'(if_id_valid), 64'd0);
      chk("mid_rst_q", 64'(if_id_q), 64'({NOP, 18'h0}));
      tick();
      stall = 1'b0; rst_n = 1'b1; #1;
      chk("rr_addr", 64'(imem_addr), 64'h000);
      tick();
      chk("rr_bubble", 64'(if_id_valid), 64'd0);
      tick();
      chk("rr_q", 64'(if_id_q), 64'({32'h0010_0093, 9'h000, 9'h004}));
      chk("rr_v", 64'(if_id_valid), 64'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
